chip_run_ctrl: RTL and testbench
================================

// Module: chip_run_ctrl
// PURPOSE
//  Synthesizable run controller for the chip. Replaces hand-timed tb reset/start/stop stimulus.
//  Sequences a core reset pulse, then asserts start, then runs until halt or a cycle budget expires.
//  Counts cycles and accepted inst/data fetches for on-chip perf readout.
//  Sits between the board/tb reset and chip (drives chip rst_n/start, observes inst_valid/data_valid).
// PARAMETERS
//  PRE_CYC   4   cycles of deasserted core reset before the reset pulse (0 = skip phase)
//  RST_CYC   2   cycles core_rst_n held low (min 1)
//  POST_CYC  2   cycles after reset release before start rises (0 = skip phase)
//  MAX_CYC   60  run-phase cycle budget; 0 = unlimited
//  CNT_W     32  width of cyc_cnt/inst_cnt/data_cnt
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous active-high reset
//  restart     in   1      pulse: abort and re-run full sequence from PRE
//  halt        in   1      core halt request (e.g. ebreak/ecall decode); sampled in RUN only
//  inst_valid  in   1      chip instruction fetch valid
//  data_valid  in   1      chip data access valid
//  core_rst_n  out  1      active-low reset to chip
//  start       out  1      start to chip; high throughout RUN only
//  running     out  1      state == RUN
//  done        out  1      state == DONE (sticky until rst/restart)
//  timeout     out  1      DONE entered by budget expiry (sticky)
//  cyc_cnt     out  CNT_W  RUN cycles elapsed
//  inst_cnt    out  CNT_W  inst_valid cycles counted in RUN
//  data_cnt    out  CNT_W  data_valid cycles counted in RUN
// BEHAVIOUR
//  - rst: state=PRE (or RST if PRE_CYC==0), phase cnt=0; core_rst_n=1, start=0, running=0,
//    done=0, timeout=0, all counters=0. All outputs registered; take effect the cycle after rst.
//  - FSM PRE -> RST -> POST -> RUN -> DONE; phase counter reloads to 0 on each state entry.
//    PRE: core_rst_n=1; leave after PRE_CYC cycles. RST: core_rst_n=0 for exactly RST_CYC cycles.
//    POST: core_rst_n=1, start=0 for POST_CYC cycles. Zero-length phases are skipped, not 1 cycle.
//  - RUN: start=1, running=1; cyc_cnt+=1 every cycle; inst_cnt/data_cnt +=1 when respective valid=1.
//    Counters saturate at all-ones, never wrap. Valids outside RUN are ignored.
//  - RUN exit: halt=1 -> DONE, timeout=0. cyc_cnt==MAX_CYC-1 (final budget cycle, MAX_CYC!=0)
//    -> DONE, timeout=1. Halt and expiry in the same cycle: halt wins, timeout=0.
//    The exit cycle is counted: cyc_cnt==MAX_CYC after timeout.
//  - DONE: start=0, core_rst_n=1; counters frozen and readable; stays until restart or rst.
//  - restart (any state, incl. mid-RST/RUN): next cycle state=PRE, counters/done/timeout
//    cleared, start=0, core_rst_n=1. rst has priority over restart.
//  - Invariants: start and !core_rst_n never both high; start==running.
// STRUCTURE
//  - Package chip_pkg: typedef enum logic [2:0] {RC_PRE,RC_RST,RC_POST,RC_RUN,RC_DONE} run_state_t;
//    default timing localparams (DEF_PRE_CYC etc.) shared with tb and chip top.
//  - One sub-module sat_counter #(W) (clr, inc -> q, saturating); instantiated 3x for perf counters.
//  - Phase counter and FSM live in this module; width $clog2(max(PRE,RST,POST,1)+1).
// TESTING
//  - Defaults, rst 2 cyc: core_rst_n low exactly cycles 5-6 after rst release, start rises cycle 9.
//  - Defaults, no halt, inst_valid=1 always: timeout=1, done=1, cyc_cnt=60, inst_cnt=60, start low after.
//  - halt pulse at RUN cycle 10 with data_valid every other cycle: done=1, timeout=0, cyc_cnt=11, data_cnt=6.
//  - halt on cycle 60 (MAX_CYC-1 index): timeout=0, cyc_cnt=60 (halt priority).
//  - restart during RST and during RUN: sequence restarts from PRE, counters read 0, full pulse re-issued.
//  - PRE_CYC=0,POST_CYC=0,MAX_CYC=0,CNT_W=4: reset at cycle 1, start next; inst_cnt saturates at 15.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared types and default timing for the chip run controller.
// The bench and the chip top use the same defaults.
package chip_pkg;

  typedef enum logic [2:0] {
    RC_PRE,
    RC_RST,
    RC_POST,
    RC_RUN,
    RC_DONE
  } run_state_t;

  localparam int DEF_PRE_CYC  = 4;
  localparam int DEF_RST_CYC  = 2;
  localparam int DEF_POST_CYC = 2;
  localparam int DEF_MAX_CYC  = 60;
  localparam int DEF_CNT_W    = 32;

  // Largest of the phase lengths, never below 1, used to size the phase counter.
  function automatic int phase_max(input int a, input int b, input int c);
    int m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/chip_run_ctrl_sat_counter.sv
// Saturating up-counter: clears on clr_i, counts on inc_i, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next value: clear wins over increment; hold once all ones is reached.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/chip_run_ctrl.sv
// Run controller: sequences chip reset, raises start, runs until halt or
// cycle budget expiry, and counts RUN cycles and fetch activity.
//
// Handshake/valid semantics: inst_valid and data_valid are single-cycle
// qualifiers with no back-pressure; each cycle in RUN with a valid high
// counts exactly once. halt is a level sampled only in RUN. restart is a
// one-cycle pulse that takes effect on the next clock edge; rst overrides it.
module chip_run_ctrl
  import chip_pkg::*;
#(
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int POST_CYC = DEF_POST_CYC,
  parameter int MAX_CYC  = DEF_MAX_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             halt,
  input  logic             inst_valid,
  input  logic             data_valid,
  output logic             core_rst_n,
  output logic             start,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] data_cnt,
  output logic [2:0]       dbg_state
);

  localparam int PH_MAX = phase_max(PRE_CYC, RST_CYC, POST_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] PRE_LAST  = PH_W'((PRE_CYC  > 0) ? PRE_CYC  - 1 : 0);
  localparam logic [PH_W-1:0] RST_LAST  = PH_W'((RST_CYC  > 0) ? RST_CYC  - 1 : 0);
  localparam logic [PH_W-1:0] POST_LAST = PH_W'((POST_CYC > 0) ? POST_CYC - 1 : 0);

  // Zero-length PRE/POST phases are skipped entirely rather than lasting a cycle.
  localparam run_state_t ENTRY_ST     = (PRE_CYC  == 0) ? RC_RST : RC_PRE;
  localparam run_state_t AFTER_RST_ST = (POST_CYC == 0) ? RC_RUN : RC_POST;

  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'((MAX_CYC > 0) ? MAX_CYC - 1 : 0);
  localparam logic             BUDGET_ON   = (MAX_CYC != 0);

  run_state_t      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            timeout_q, timeout_d;
  logic            core_rst_n_q;
  logic            run_q;
  logic            done_q;
  logic            expire;
  logic            cnt_clr;
  logic            in_run;

  assign in_run = (state_q == RC_RUN);
  // The budget check uses the count before this cycle's increment, so the
  // exit cycle itself is still counted and cyc_cnt lands on MAX_CYC.
  assign expire = BUDGET_ON && (cyc_cnt == BUDGET_LAST);

  // Next-state logic: phase timing, run exit, restart override.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PH_W'(1);
    timeout_d = timeout_q;
    case (state_q)
      RC_PRE: begin
        if (phase_q == PRE_LAST) begin
          state_d = RC_RST;
          phase_d = '0;
        end
      end
      RC_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = AFTER_RST_ST;
          phase_d = '0;
        end
      end
      RC_POST: begin
        if (phase_q == POST_LAST) begin
          state_d = RC_RUN;
          phase_d = '0;
        end
      end
      RC_RUN: begin
        phase_d = '0;
        if (halt) begin
          state_d = RC_DONE;
        end else if (expire) begin
          state_d   = RC_DONE;
          timeout_d = 1'b1;
        end
      end
      RC_DONE: begin
        phase_d = '0;
      end
      default: begin
        state_d = ENTRY_ST;
        phase_d = '0;
      end
    endcase
    if (restart) begin
      state_d   = ENTRY_ST;
      phase_d   = '0;
      timeout_d = 1'b0;
    end
  end

  // State register plus outputs registered from the next state so they
  // line up with state_q. While rst is held the outputs show the entry state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENTRY_ST;
      phase_q      <= '0;
      timeout_q    <= 1'b0;
      core_rst_n_q <= (ENTRY_ST != RC_RST);
      run_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      timeout_q    <= timeout_d;
      core_rst_n_q <= (state_d != RC_RST);
      run_q        <= (state_d == RC_RUN);
      done_q       <= (state_d == RC_DONE);
    end
  end

  assign cnt_clr = rst | restart;

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk_i (clk),
    .clr_i (cnt_clr),
    .inc_i (in_run),
    .q_o   (cyc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .clk_i (clk),
    .clr_i (cnt_clr),
    .inc_i (in_run & inst_valid),
    .q_o   (inst_cnt)
  );

  sat_counter #(.W(CNT_W)) u_data_cnt (
    .clk_i (clk),
    .clr_i (cnt_clr),
    .inc_i (in_run & data_valid),
    .q_o   (data_cnt)
  );

  assign core_rst_n = core_rst_n_q;
  assign start      = run_q;
  assign running    = run_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_chip_run_ctrl.sv
// Bench for chip_run_ctrl: default-parameter instance plus a small
// instance with skipped phases, unlimited budget and 4-bit counters.
module tb_chip_run_ctrl;
  import chip_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, restart = 1'b0, halt = 1'b0;
  logic        inst_valid = 1'b0, data_valid = 1'b0;
  logic        core_rst_n, start, running, done, timeout;
  logic [31:0] cyc_cnt, inst_cnt, data_cnt;
  logic [2:0]  dbg_state;

  logic        rst_s = 1'b1, inst_valid_s = 1'b0;
  logic        restart_s = 1'b0, halt_s = 1'b0, data_valid_s = 1'b0;
  logic        core_rst_n_s, start_s, running_s, done_s, timeout_s;
  logic [3:0]  cyc_cnt_s, inst_cnt_s, data_cnt_s;
  logic [2:0]  dbg_state_s;

  chip_run_ctrl dut (
    .clk(clk), .rst(rst), .restart(restart), .halt(halt),
    .inst_valid(inst_valid), .data_valid(data_valid),
    .core_rst_n(core_rst_n), .start(start), .running(running),
    .done(done), .timeout(timeout), .cyc_cnt(cyc_cnt),
    .inst_cnt(inst_cnt), .data_cnt(data_cnt), .dbg_state(dbg_state)
  );

  chip_run_ctrl #(.PRE_CYC(0), .RST_CYC(1), .POST_CYC(0), .MAX_CYC(0), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst_s), .restart(restart_s), .halt(halt_s),
    .inst_valid(inst_valid_s), .data_valid(data_valid_s),
    .core_rst_n(core_rst_n_s), .start(start_s), .running(running_s),
    .done(done_s), .timeout(timeout_s), .cyc_cnt(cyc_cnt_s),
    .inst_cnt(inst_cnt_s), .data_cnt(data_cnt_s), .dbg_state(dbg_state_s)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the first cycle after rst release (cycle 1).
  task automatic do_reset();
    halt = 1'b0; restart = 1'b0; inst_valid = 1'b0; data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Checks the chip reset / start waveform for cycles 1..12 starting now.
  task automatic check_sequence(input string name);
    logic exp_rn, exp_st;
    for (int c = 1; c <= 12; c++) begin
      exp_rn = !(c == 5 || c == 6);
      exp_st = (c >= 9);
      n_cmp++;
      if (core_rst_n !== exp_rn) begin
        n_fail++;
        $display("FAIL %s_core_rst_n cycle %0d: got %b expected %b", name, c, core_rst_n, exp_rn);
      end
      n_cmp++;
      if (start !== exp_st) begin
        n_fail++;
        $display("FAIL %s_start cycle %0d: got %b expected %b", name, c, start, exp_st);
      end
      n_cmp++;
      if (running !== exp_st) begin
        n_fail++;
        $display("FAIL %s_running cycle %0d: got %b expected %b", name, c, running, exp_st);
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    inst_valid = 1'($urandom_range(0, 1));
    data_valid = 1'($urandom_range(0, 1));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({core_rst_n, start, running, done, timeout} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected %b", {core_rst_n, start, running, done, timeout}, 5'b10000);
    end
    n_cmp++;
    if ({cyc_cnt, inst_cnt, data_cnt} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cyc_cnt, inst_cnt, data_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    do_reset();
    check_sequence("seq");
  endtask

  // One full run; the model counts what it drives inside RUN and pushes the
  // expected readout when it drives the exit cycle.
  task automatic run_case(input string name, input int halt_idx, input bit inst_all, input bit data_alt);
    int m_cyc, m_inst, m_data;
    bit ended;
    logic [31:0] e_cyc, e_inst, e_data, e_to;
    m_cyc = 0; m_inst = 0; m_data = 0; ended = 1'b0;
    do_reset();
    for (int c = 1; !ended && c < 200; c++) begin
      if (c >= 9) begin
        halt       = (m_cyc == halt_idx);
        inst_valid = inst_all;
        data_valid = data_alt && (m_cyc % 2 == 0);
        m_cyc++;
        m_inst += int'(inst_valid);
        m_data += int'(data_valid);
        if (halt) begin
          exp_q.push_back(32'(m_cyc)); exp_q.push_back(32'(m_inst));
          exp_q.push_back(32'(m_data)); exp_q.push_back(32'd0);
          ended = 1'b1;
        end else if (m_cyc == 60) begin
          exp_q.push_back(32'(m_cyc)); exp_q.push_back(32'(m_inst));
          exp_q.push_back(32'(m_data)); exp_q.push_back(32'd1);
          ended = 1'b1;
        end
      end else begin
        halt       = 1'($urandom_range(0, 1));
        inst_valid = 1'($urandom_range(0, 1));
        data_valid = 1'($urandom_range(0, 1));
      end
      step();
    end
    halt = 1'b0;
    for (int w = 0; w < 4 && done !== 1'b1; w++) step();
    n_cmp++;
    if (done !== 1'b1 || exp_q.size() < 4) begin
      n_fail++;
      $display("FAIL %s_done: got %b expected 1", name, done);
      exp_q.delete();
    end else begin
      e_cyc = exp_q.pop_front(); e_inst = exp_q.pop_front();
      e_data = exp_q.pop_front(); e_to = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (cyc_cnt !== e_cyc) begin
          n_fail++; $display("FAIL %s_cyc_cnt: got %0d expected %0d", name, cyc_cnt, e_cyc);
        end
        n_cmp++;
        if (inst_cnt !== e_inst) begin
          n_fail++; $display("FAIL %s_inst_cnt: got %0d expected %0d", name, inst_cnt, e_inst);
        end
        n_cmp++;
        if (data_cnt !== e_data) begin
          n_fail++; $display("FAIL %s_data_cnt: got %0d expected %0d", name, data_cnt, e_data);
        end
        n_cmp++;
        if (timeout !== e_to[0]) begin
          n_fail++; $display("FAIL %s_timeout: got %b expected %b", name, timeout, e_to[0]);
        end
        n_cmp++;
        if ({start, running, core_rst_n, done} !== 4'b0011) begin
          n_fail++; $display("FAIL %s_done_outputs: got %b expected 0011", name, {start, running, core_rst_n, done});
        end
        // Activity after DONE must leave everything frozen.
        inst_valid = 1'b1; data_valid = 1'b1; halt = 1'($urandom_range(0, 1));
        repeat (3) step();
        halt = 1'b0;
      end
    end
    inst_valid = 1'b0; data_valid = 1'b0;
  endtask

  task automatic test_restart_rst();
    do_reset();
    repeat (4) step();
    n_cmp++;
    if (core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL rrst_in_rst: got %b expected 0", core_rst_n);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_sequence("rrst");
  endtask

  task automatic test_restart_run();
    do_reset();
    inst_valid = 1'b1;
    repeat (19) step();
    n_cmp++;
    if (inst_cnt !== 32'd11 || cyc_cnt !== 32'd11) begin
      n_fail++; $display("FAIL rrun_mid_counts: got %0d/%0d expected 11/11", cyc_cnt, inst_cnt);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    inst_valid = 1'b0;
    n_cmp++;
    if ({cyc_cnt, inst_cnt, data_cnt} !== 96'd0) begin
      n_fail++; $display("FAIL rrun_cleared: got %0d/%0d/%0d expected 0/0/0", cyc_cnt, inst_cnt, data_cnt);
    end
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin
      n_fail++; $display("FAIL rrun_flags: got %b expected 00", {done, timeout});
    end
    check_sequence("rrun");
  endtask

  task automatic test_small_saturate();
    logic [31:0] model;
    logic [31:0] e;
    inst_valid_s = 1'b1;
    rst_s = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    n_cmp++;
    if ({core_rst_n_s, start_s} !== 2'b00) begin
      n_fail++; $display("FAIL small_cycle1: got %b expected 00", {core_rst_n_s, start_s});
    end
    step();
    n_cmp++;
    if ({core_rst_n_s, start_s, running_s} !== 3'b111) begin
      n_fail++; $display("FAIL small_cycle2: got %b expected 111", {core_rst_n_s, start_s, running_s});
    end
    model = 0;
    for (int i = 0; i < 20; i++) begin
      inst_valid_s = 1'($urandom_range(0, 3) != 0) | (i >= 10);
      if (inst_valid_s && model < 15) model++;
      exp_q.push_back(model);
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(inst_cnt_s) !== e) begin
        n_fail++; $display("FAIL small_inst_cnt step %0d: got %0d expected %0d", i, inst_cnt_s, e);
      end
    end
    n_cmp++;
    if ({cyc_cnt_s, inst_cnt_s} !== 8'hff) begin
      n_fail++; $display("FAIL small_saturated: got %0d/%0d expected 15/15", cyc_cnt_s, inst_cnt_s);
    end
    n_cmp++;
    if ({done_s, timeout_s, running_s} !== 3'b001) begin
      n_fail++; $display("FAIL small_unlimited: got %b expected 001", {done_s, timeout_s, running_s});
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_sequence();
    run_case("timeout", -1, 1'b1, 1'b0);
    test_reset();
    run_case("halt10", 10, 1'b0, 1'b1);
    run_case("halt_last", 59, 1'b1, 1'b1);
    test_restart_rst();
    test_restart_run();
    test_small_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
